alu_issue: RTL and testbench

- Initiator side of the ALU operation interface (srcA/srcB/oper in, result/zero/less_then_zero back).
- Accepts one decoded-register-read instruction per transaction and decodes the MIPS opcode/funct into a 4-bit ALU oper code.
- Builds srcA/srcB from register data, sign/zero-extended immediate or shamt, drives the combinational ALU and captures result and flags.
- Returns writeback/branch info downstream over valid/ready; sits between register read and writeback in the multi-cycle core.

---
 rtl/alu_issue_pkg.sv | 82 ++++++++
 rtl/alu_issue_decode.sv | 132 +++++++++++++
 rtl/alu_issue.sv | 114 +++++++++++
 tb/tb_alu_issue.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared command definitions for the ALU issue stage: ALU operation codes,
// MIPS opcode/funct constants, FSM state encodings and the decoded command
// record handed from the decoder to the issue FSM.
package alu_issue_pkg;

  // Operation codes understood by the external combinational ALU.
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_OR  = 4'd1,
    ALU_SRL = 4'd2,
    ALU_SLT = 4'd3,
    ALU_SUB = 4'd4,
    ALU_SLL = 4'd5,
    ALU_NOR = 4'd6,
    ALU_SRA = 4'd7,
    ALU_XOR = 4'd8,
    ALU_AND = 4'd9
  } alu_oper_e;

  // Primary opcodes.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  // R-type funct codes.
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  // Flipping bit 31 of both operands maps signed order onto unsigned order,
  // so the unsigned-only ALU compare yields a signed less-than.
  localparam logic [31:0] SIGN_BIAS = 32'h8000_0000;

  // Issue FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Fully decoded instruction, ready to be registered in front of the ALU.
  typedef struct packed {
    logic [31:0] src_a;
    logic [31:0] src_b;
    alu_oper_e   oper;
    logic [4:0]  wa;
    logic        we;
    logic        is_beq;
    logic        is_bne;
    logic        illegal;
  } issue_cmd_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] imm);
    return {16'd0, imm};
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational MIPS decoder: maps an instruction word plus its register
// operands onto ALU operands, ALU operation and writeback/branch controls.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output issue_cmd_t  cmd
);

  logic [5:0]  opcode;
  logic [4:0]  rt_field;
  logic [4:0]  rd_field;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [4:0]  unused_rs_field;

  assign opcode          = instr[31:26];
  assign rt_field        = instr[20:16];
  assign rd_field        = instr[15:11];
  assign shamt           = instr[10:6];
  assign funct           = instr[5:0];
  assign imm             = instr[15:0];
  // Operand values arrive already read from the register file.
  assign unused_rs_field = instr[25:21];

  logic [31:0] src_a;
  logic [31:0] src_b;
  alu_oper_e   oper;
  logic [4:0]  wa;
  logic        writes;
  logic        is_beq;
  logic        is_bne;
  logic        legal;

  // Decode opcode/funct into operand selection, ALU operation and controls.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    src_a  = '0;
    src_b  = '0;
    oper   = ALU_ADD;
    wa     = '0;
    writes = 1'b0;
    is_beq = 1'b0;
    is_bne = 1'b0;
    legal  = 1'b1;

    case (opcode)
      OP_RTYPE: begin
        wa     = rd_field;
        writes = 1'b1;
        src_a  = rs;
        src_b  = rt;
        case (funct)
          F_ADD, F_ADDU: oper = ALU_ADD;
          F_SUB, F_SUBU: oper = ALU_SUB;
          F_AND:         oper = ALU_AND;
          F_OR:          oper = ALU_OR;
          F_XOR:         oper = ALU_XOR;
          F_NOR:         oper = ALU_NOR;
          F_SLTU:        oper = ALU_SLT;
          F_SLT: begin
            oper  = ALU_SLT;
            src_a = rs ^ SIGN_BIAS;
            src_b = rt ^ SIGN_BIAS;
          end
          F_SLL: begin oper = ALU_SLL; src_a = rt; src_b = {27'd0, shamt}; end
          F_SRL: begin oper = ALU_SRL; src_a = rt; src_b = {27'd0, shamt}; end
          F_SRA: begin oper = ALU_SRA; src_a = rt; src_b = {27'd0, shamt}; end
          F_SLLV: begin oper = ALU_SLL; src_a = rt; src_b = rs; end
          F_SRLV: begin oper = ALU_SRL; src_a = rt; src_b = rs; end
          F_SRAV: begin oper = ALU_SRA; src_a = rt; src_b = rs; end
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        wa = rt_field; writes = 1'b1;
        oper = ALU_ADD; src_a = rs; src_b = sext16(imm);
      end
      OP_ANDI: begin
        wa = rt_field; writes = 1'b1;
        oper = ALU_AND; src_a = rs; src_b = zext16(imm);
      end
      OP_ORI: begin
        wa = rt_field; writes = 1'b1;
        oper = ALU_OR; src_a = rs; src_b = zext16(imm);
      end
      OP_XORI: begin
        wa = rt_field; writes = 1'b1;
        oper = ALU_XOR; src_a = rs; src_b = zext16(imm);
      end
      OP_SLTIU: begin
        wa = rt_field; writes = 1'b1;
        oper = ALU_SLT; src_a = rs; src_b = sext16(imm);
      end
      OP_SLTI: begin
        wa = rt_field; writes = 1'b1;
        oper  = ALU_SLT;
        src_a = rs ^ SIGN_BIAS;
        src_b = sext16(imm) ^ SIGN_BIAS;
      end
      OP_LUI: begin
        wa = rt_field; writes = 1'b1;
        oper = ALU_SLL; src_a = zext16(imm); src_b = 32'd16;
      end
      OP_BEQ: begin
        oper = ALU_SUB; src_a = rs; src_b = rt; is_beq = 1'b1;
      end
      OP_BNE: begin
        oper = ALU_SUB; src_a = rs; src_b = rt; is_bne = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal instructions run ADD(0,0) and suppress every side effect;
  // writes to register 0 are dropped.
  always_comb begin
    cmd.src_a   = legal ? src_a : '0;
    cmd.src_b   = legal ? src_b : '0;
    cmd.oper    = legal ? oper : ALU_ADD;
    cmd.wa      = legal ? wa : '0;
    cmd.we      = legal && writes && (wa != 5'd0);
    cmd.is_beq  = legal && is_beq;
    cmd.is_bne  = legal && is_bne;
    cmd.illegal = !legal;
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: accepts one register-read instruction, drives the external
// combinational ALU for one cycle from registered operands, captures result
// and flags, and holds the response until the downstream stage takes it.
// out_valid rises at edge N+1 after accept edge N, so downstream first
// samples it at edge N+2; a full op takes three cycles.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs,
  input  logic [31:0] in_rt,
  output logic [31:0] alu_srcA,
  output logic [31:0] alu_srcB,
  output logic [3:0]  alu_oper,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_ltz,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_wa,
  output logic        out_we,
  output logic        out_branch,
  output logic        out_illegal
);

  issue_cmd_t cmd;
  state_e     state;
  logic [4:0] wa_q;
  logic       we_q;
  logic       beq_q;
  logic       bne_q;
  logic       illegal_q;
  logic       unused_ltz;

  // Branch decisions only need the zero flag.
  assign unused_ltz = alu_ltz;

  // The incoming instruction is decoded before it is registered, so the
  // ALU operand registers are already valid for the whole EXEC cycle.
  alu_issue_decode u_decode (
    .instr (in_instr),
    .rs    (in_rs),
    .rt    (in_rt),
    .cmd   (cmd)
  );

  // Issue FSM: accept in IDLE, capture ALU output in EXEC, hand off in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      in_ready    <= 1'b1;
      alu_srcA    <= '0;
      alu_srcB    <= '0;
      alu_oper    <= ALU_ADD;
      wa_q        <= '0;
      we_q        <= 1'b0;
      beq_q       <= 1'b0;
      bne_q       <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_wa      <= '0;
      out_we      <= 1'b0;
      out_branch  <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            alu_srcA  <= cmd.src_a;
            alu_srcB  <= cmd.src_b;
            alu_oper  <= cmd.oper;
            wa_q      <= cmd.wa;
            we_q      <= cmd.we;
            beq_q     <= cmd.is_beq;
            bne_q     <= cmd.is_bne;
            illegal_q <= cmd.illegal;
            in_ready  <= 1'b0;
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          out_result  <= illegal_q ? 32'd0 : alu_result;
          out_wa      <= wa_q;
          out_we      <= we_q;
          out_branch  <= (beq_q && alu_zero) || (bne_q && !alu_zero);
          out_illegal <= illegal_q;
          out_valid   <= 1'b1;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: a behavioural ALU answers the DUT, a table of
// hand-computed vectors covers decode, and short sequences cover
// backpressure and reset in the middle of an operation.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs;
  logic [31:0] in_rt;
  logic [31:0] alu_srcA;
  logic [31:0] alu_srcB;
  logic [3:0]  alu_oper;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_ltz;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_wa;
  logic        out_we;
  logic        out_branch;
  logic        out_illegal;

  int n_checks = 0;
  int n_pass   = 0;

  alu_issue dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .alu_srcA    (alu_srcA),
    .alu_srcB    (alu_srcB),
    .alu_oper    (alu_oper),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .alu_ltz     (alu_ltz),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_wa      (out_wa),
    .out_we      (out_we),
    .out_branch  (out_branch),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  // Behavioural ALU on the far side of the interface.
  always_comb begin
    alu_result = 32'd0;
    case (alu_oper)
      4'd0: alu_result = alu_srcA + alu_srcB;
      4'd1: alu_result = alu_srcA | alu_srcB;
      4'd2: alu_result = alu_srcA >> alu_srcB[4:0];
      4'd3: alu_result = {31'd0, alu_srcA < alu_srcB};
      4'd4: alu_result = alu_srcA - alu_srcB;
      4'd5: alu_result = alu_srcA << alu_srcB[4:0];
      4'd6: alu_result = ~(alu_srcA | alu_srcB);
      4'd7: alu_result = $unsigned($signed(alu_srcA) >>> alu_srcB[4:0]);
      4'd8: alu_result = alu_srcA ^ alu_srcB;
      4'd9: alu_result = alu_srcA & alu_srcB;
      default: alu_result = 32'd0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);
  assign alu_ltz  = alu_result[31];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] result;
    logic [4:0]  wa;
    logic        we;
    logic        branch;
    logic        illegal;
    logic [3:0]  oper;
    logic        chk_srcb;
    logic [31:0] srcb;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] rs,
                              input logic [31:0] rt, input logic [31:0] result,
                              input logic [4:0] wa, input logic we,
                              input logic branch, input logic illegal,
                              input logic [3:0] oper, input logic chk_srcb,
                              input logic [31:0] srcb);
    vec_t v;
    v.instr = instr; v.rs = rs; v.rt = rt; v.result = result; v.wa = wa;
    v.we = we; v.branch = branch; v.illegal = illegal; v.oper = oper;
    v.chk_srcb = chk_srcb; v.srcb = srcb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Issue one instruction, check EXEC and RESP contents, optionally hold
  // out_ready low for `hold` cycles while offering a competing request.
  task automatic run_vec(input vec_t v, input string tag, input int hold);
    int waited = 0;
    @(negedge clk);
    in_instr  = v.instr;
    in_rs     = v.rs;
    in_rt     = v.rt;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " in_ready before accept"}, in_ready, 1);
    @(posedge clk);            // accept edge N
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, " exec out_valid"}, out_valid, 0);
    check({tag, " exec in_ready"}, in_ready, 0);
    check({tag, " alu_oper"}, alu_oper, v.oper);
    if (v.chk_srcb) check({tag, " alu_srcB"}, alu_srcB, v.srcb);
    @(negedge clk);            // after edge N+1, before edge N+2
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " out_result"}, out_result, v.result);
    check({tag, " out_wa"}, out_wa, v.wa);
    check({tag, " out_we"}, out_we, v.we);
    check({tag, " out_branch"}, out_branch, v.branch);
    check({tag, " out_illegal"}, out_illegal, v.illegal);
    for (int i = 0; i < hold; i++) begin
      in_instr = 32'h2009_0001;   // competing addi must be ignored
      in_valid = 1'b1;
      @(negedge clk);
      check({tag, " hold out_valid"}, out_valid, 1);
      check({tag, " hold in_ready"}, in_ready, 0);
      check({tag, " hold out_result"}, out_result, v.result);
      check({tag, " hold out_wa"}, out_wa, v.wa);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " done out_valid"}, out_valid, 0);
    check({tag, " done in_ready"}, in_ready, 1);
  endtask

  vec_t vecs [0:17];

  initial begin
    vecs[0]  = mk(32'h2008FFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 5'd8, 1, 0, 0, 4'd0, 0, 0);      // addi $8,$0,-1
    vecs[1]  = mk(32'h0022182A, 32'hFFFFFFFF, 32'h1, 32'h1, 5'd3, 1, 0, 0, 4'd3, 0, 0);     // slt
    vecs[2]  = mk(32'h0022182B, 32'hFFFFFFFF, 32'h1, 32'h0, 5'd3, 1, 0, 0, 4'd3, 0, 0);     // sltu
    vecs[3]  = mk(32'h3C011234, 32'h0, 32'h0, 32'h12340000, 5'd1, 1, 0, 0, 4'd5, 1, 32'd16); // lui
    vecs[4]  = mk(32'h10220000, 32'd5, 32'd5, 32'h0, 5'd0, 0, 1, 0, 4'd4, 0, 0);            // beq taken
    vecs[5]  = mk(32'h14220000, 32'd5, 32'd5, 32'h0, 5'd0, 0, 0, 0, 4'd4, 0, 0);            // bne not taken
    vecs[6]  = mk(32'h10220000, 32'd5, 32'd6, 32'hFFFFFFFF, 5'd0, 0, 0, 0, 4'd4, 0, 0);     // beq not taken
    vecs[7]  = mk(32'h00222020, 32'd7, 32'd9, 32'h10, 5'd4, 1, 0, 0, 4'd0, 0, 0);           // add
    vecs[8]  = mk(32'h00222822, 32'd1, 32'd2, 32'hFFFFFFFF, 5'd5, 1, 0, 0, 4'd4, 0, 0);     // sub wraps
    vecs[9]  = mk(32'h00023103, 32'h0, 32'h80000000, 32'hF8000000, 5'd6, 1, 0, 0, 4'd7, 1, 32'd4); // sra 4
    vecs[10] = mk(32'h00223806, 32'd8, 32'h80000000, 32'h00800000, 5'd7, 1, 0, 0, 4'd2, 1, 32'd8); // srlv
    vecs[11] = mk(32'h00224827, 32'h0F0F0F0F, 32'h00FF00FF, 32'hF000F000, 5'd9, 1, 0, 0, 4'd6, 0, 0); // nor
    vecs[12] = mk(32'h342A8001, 32'h10000000, 32'h0, 32'h10008001, 5'd10, 1, 0, 0, 4'd1, 0, 0); // ori zext
    vecs[13] = mk(32'h282BFFFF, 32'hFFFFFFFE, 32'h0, 32'h1, 5'd11, 1, 0, 0, 4'd3, 0, 0);    // slti signed
    vecs[14] = mk(32'h00220021, 32'd3, 32'd4, 32'd7, 5'd0, 0, 0, 0, 4'd0, 0, 0);            // addu to $0
    vecs[15] = mk(32'hFC000000, 32'd5, 32'd6, 32'h0, 5'd0, 0, 0, 1, 4'd0, 1, 32'd0);        // illegal opcode
    vecs[16] = mk(32'h00220801, 32'd5, 32'd6, 32'h0, 5'd0, 0, 0, 1, 4'd0, 1, 32'd0);        // illegal funct
    vecs[17] = mk(32'h302C00F0, 32'h12345678, 32'h0, 32'h70, 5'd12, 1, 0, 0, 4'd9, 0, 0);   // andi

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_rs     = '0;
    in_rt     = '0;
    out_ready = 1'b0;
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out_we", out_we, 0);
    check("reset out_branch", out_branch, 0);
    check("reset out_illegal", out_illegal, 0);
    check("reset out_result", out_result, 0);
    check("reset out_wa", out_wa, 0);
    check("reset alu_srcA", alu_srcA, 0);
    check("reset alu_srcB", alu_srcB, 0);
    check("reset alu_oper", alu_oper, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i <= 16; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i), 0);
    end

    // Backpressure: response held for 3 cycles with a competing request.
    run_vec(vecs[17], "bp_andi", 3);
    run_vec(vecs[15], "bp_illegal", 0);

    // Reset during EXEC drops the transaction.
    @(negedge clk);
    in_instr = 32'h00222020; in_rs = 32'd1; in_rt = 32'd2; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre-reset in EXEC in_ready", in_ready, 0);
    rst = 1'b1;
    #1;
    check("midrst out_valid", out_valid, 0);
    check("midrst in_ready", in_ready, 1);
    check("midrst alu_srcA", alu_srcA, 0);
    check("midrst alu_oper", alu_oper, 0);
    check("midrst out_result", out_result, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post-reset no stale out_valid", out_valid, 0);
    end
    run_vec(vecs[8], "after_reset_sub", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
